// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared types and defaults for the stochastic-computing decoder blocks.
//   sc_dec_state_t    : decoder FSM states (IDLE, ACCUM)
//   SC_DEFAULT_CNT_W  : default accumulator / result width
//   SC_DEFAULT_WINDOW : default samples per conversion (8-bit LFSR period)
// -----------------------------------------------------------------------------
package sc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } sc_dec_state_t;

   localparam int SC_DEFAULT_CNT_W  = 8;
   localparam int SC_DEFAULT_WINDOW = 255;

endpackage : sc_pkg

// File: rtl/sc_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder_if
// Bundles the control, bitstream and result signals of sc_stream_decoder.
//   start       : one-cycle pulse, begins/restarts a conversion window
//   bit_in      : stochastic bitstream sample
//   bit_valid   : bit_in carries a valid sample this cycle
//   busy        : a window is accumulating
//   done        : one-cycle pulse, count_out updated this cycle
//   count_out   : ones count of the last completed window
//   bipolar_out : 2*count - WINDOW (only with SC_DECODER_BIPOLAR_EN defined)
// Modports: master drives stimulus and observes results; slave is the decoder.
// Optional feature macro: SC_DECODER_BIPOLAR_EN
// -----------------------------------------------------------------------------
interface sc_stream_decoder_if
   import sc_pkg::*;
#(
   parameter int CNT_W = SC_DEFAULT_CNT_W
) ();

   logic             start;
   logic             bit_in;
   logic             bit_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count_out;
`ifdef SC_DECODER_BIPOLAR_EN
   logic signed [CNT_W:0] bipolar_out;
`endif

`ifdef SC_DECODER_BIPOLAR_EN
   modport master (
      output start, bit_in, bit_valid,
      input  busy, done, count_out, bipolar_out
   );
   modport slave (
      input  start, bit_in, bit_valid,
      output busy, done, count_out, bipolar_out
   );
`else
   modport master (
      output start, bit_in, bit_valid,
      input  busy, done, count_out
   );
   modport slave (
      input  start, bit_in, bit_valid,
      output busy, done, count_out
   );
`endif

endinterface : sc_stream_decoder_if

// File: rtl/sc_ones_counter.sv
// -----------------------------------------------------------------------------
// sc_ones_counter
// Clearable, enabled ones accumulator: count += bit_in whenever en is high.
// clear has priority over en.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronously zero the count
//   en       : accumulate bit_in this cycle
//   bit_in   : bit to add
//   count    : running ones count
// -----------------------------------------------------------------------------
module sc_ones_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   input  logic         bit_in,
   output logic [W-1:0] count
);

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        count <= '0;
      else if (clear) count <= '0;
      else if (en)    count <= count + W'(bit_in);
   end

endmodule : sc_ones_counter

// File: rtl/sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder
// Stochastic-to-binary decoder: counts the ones among WINDOW valid samples of
// a unipolar bitstream and publishes the count (value = count_out / WINDOW).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : sc_stream_decoder_if.slave (start, bit_in, bit_valid in;
//              busy, done, count_out [, bipolar_out] out)
// Parameters: CNT_W (accumulator width), WINDOW (1 .. 2^CNT_W-1).
// Optional feature macro: SC_DECODER_BIPOLAR_EN adds bipolar_out = 2*count-WINDOW.
// -----------------------------------------------------------------------------
module sc_stream_decoder
   import sc_pkg::*;
#(
   parameter int CNT_W  = SC_DEFAULT_CNT_W,
   parameter int WINDOW = SC_DEFAULT_WINDOW
) (
   input  logic               clk,
   input  logic               rst,
   sc_stream_decoder_if.slave bus
);

   if (WINDOW < 1 || WINDOW > (2**CNT_W) - 1) begin : g_bad_window
      $error("sc_stream_decoder: WINDOW must be in 1 .. 2^CNT_W-1");
   end

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

   sc_dec_state_t    state, state_nxt;
   logic [CNT_W-1:0] samples;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_final;
   logic             acc_clear;
   logic             acc_en;
   logic             last_sample;

   sc_ones_counter #(.W(CNT_W)) u_ones (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .en     (acc_en),
      .bit_in (bus.bit_in),
      .count  (acc)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; start (abort/restart) outranks completion
   always_comb begin
      // NOTE: default assignment first so every path drives state_nxt and no
      // latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ACCUM;
         ACCUM:   if (!bus.start && bus.bit_valid && samples == LAST_IDX)
                     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      bus.busy    = 1'b0;
      acc_clear   = bus.start;
      acc_en      = 1'b0;
      last_sample = 1'b0;
      if (state == ACCUM) begin
         bus.busy    = 1'b1;
         acc_en      = bus.bit_valid && !bus.start;
         last_sample = acc_en && (samples == LAST_IDX);
      end
   end

   // The final sample has not reached acc yet, so fold it in here.
   assign acc_final = acc + CNT_W'(bus.bit_in);

   // Window sample counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            samples <= '0;
      else if (bus.start) samples <= '0;
      else if (acc_en)    samples <= last_sample ? '0 : samples + 1'b1;
   end

   // Result registers: updated only on completion, held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.done      <= 1'b0;
         bus.count_out <= '0;
      end else begin
         bus.done <= last_sample;
         if (last_sample) bus.count_out <= acc_final;
      end
   end

`ifdef SC_DECODER_BIPOLAR_EN
   localparam logic [CNT_W:0] WINDOW_EXT = (CNT_W+1)'(WINDOW);

   // 2*count - WINDOW in CNT_W+1 bits; modular wrap of the intermediate
   // doubling is harmless because the true result always fits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              bus.bipolar_out <= $signed(-WINDOW_EXT);
      else if (last_sample) bus.bipolar_out <= $signed({acc_final, 1'b0} - WINDOW_EXT);
   end
`endif

endmodule : sc_stream_decoder

// File: tb/tb_sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_stream_decoder
// Self-checking bench for sc_stream_decoder (CNT_W=8, WINDOW=255).
// Stimulus pushes the expected {count, done cycle} for each completing window
// into a scoreboard; a negedge monitor pops on every done and also checks that
// count_out holds its value between completions.
// Optional feature macro: SC_DECODER_BIPOLAR_EN (bipolar_out also checked).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_stream_decoder;
   import sc_pkg::*;

   localparam int CNT_W  = 8;
   localparam int WINDOW = 255;

   typedef struct {
      int cnt;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   model_count = 0;
   exp_t sb[$];

   sc_stream_decoder_if #(.CNT_W(CNT_W)) bus ();

   sc_stream_decoder #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: pops on done, otherwise confirms count_out is held.
   always @(negedge clk) begin
      if (rst) begin
         model_count = 0;
      end else if (bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("count_out", int'(bus.count_out), e.cnt);
`ifdef SC_DECODER_BIPOLAR_EN
            check("bipolar_out", int'(bus.bipolar_out), 2 * e.cnt - WINDOW);
`endif
            model_count = e.cnt;
         end
      end else begin
         check("count_held", int'(bus.count_out), model_count);
      end
   end

   task automatic drive(input logic s, input logic v, input logic b);
      bus.start     = s;
      bus.bit_valid = v;
      bus.bit_in    = b;
      @(posedge clk);
      #1;
   endtask

   function automatic logic pat_bit(input int mode, input int i);
      case (mode)
         0:       return 1'b0;          // all zeros
         1:       return 1'b1;          // all ones
         2:       return (i % 2) == 0;  // 1,0,1,...
         default: return i < 10;        // 10 ones then zeros
      endcase
   endfunction

   // n consecutive valid samples; exp >= 0 expects a done after the last one
   task automatic window(input int n, input int mode, input int exp);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1 && exp >= 0) sb.push_back('{cnt: exp, cyc: cyc + 1});
         drive(1'b0, 1'b1, pat_bit(mode, i));
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and idle with bit_valid toggling
      check("reset_count", int'(bus.count_out), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
`ifdef SC_DECODER_BIPOLAR_EN
      check("reset_bipolar", int'(bus.bipolar_out), -WINDOW);
`endif
      for (int i = 0; i < 10; i++) drive(1'b0, i[0], 1'b1);
      check("idle_busy", int'(bus.busy), 0);

      // All ones; start-cycle bit is not counted
      drive(1'b1, 1'b1, 1'b1);
      check("accum_busy", int'(bus.busy), 1);
      window(WINDOW, 1, 255);
      check("busy_falls_with_done", int'(bus.busy), 0);
      drive(1'b0, 1'b0, 1'b0);

      // Alternating, then start in the done cycle with all zeros
      drive(1'b1, 1'b0, 1'b0);
      window(WINDOW, 2, 128);
      drive(1'b1, 1'b0, 1'b0);
      window(WINDOW, 0, 0);
      drive(1'b0, 1'b0, 1'b0);

      // bit_valid every other cycle; invalid cycles carry bit_in=1
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < WINDOW; i++) begin
         drive(1'b0, 1'b0, 1'b1);
         if (i == WINDOW - 1) sb.push_back('{cnt: 255, cyc: cyc + 1});
         drive(1'b0, 1'b1, 1'b1);
      end
      drive(1'b0, 1'b0, 1'b0);

      // Abort after 100 ones, then full window of zeros
      drive(1'b1, 1'b0, 1'b0);
      window(100, 1, -1);
      drive(1'b1, 1'b0, 1'b0);
      check("busy_after_abort", int'(bus.busy), 1);
      window(WINDOW, 0, 0);
      drive(1'b0, 1'b0, 1'b0);

      // start coincides with the 255th sample: start wins, no done
      drive(1'b1, 1'b0, 1'b0);
      window(WINDOW - 1, 1, -1);
      drive(1'b1, 1'b1, 1'b1);
      check("busy_after_start_on_last", int'(bus.busy), 1);
      window(WINDOW, 2, 128);
      drive(1'b0, 1'b0, 1'b0);

      // Reset mid-window
      drive(1'b1, 1'b0, 1'b0);
      window(50, 1, -1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_count", int'(bus.count_out), 0);
      check("midrst_done", int'(bus.done), 0);
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b1);
      check("post_rst_busy", int'(bus.busy), 0);
      drive(1'b1, 1'b0, 1'b0);
      window(WINDOW, 3, 10);

      repeat (5) drive(1'b0, 1'b0, 1'b0);
      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sc_stream_decoder

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary decoder: the receiving end of the LFSR-plus-comparator stochastic number generator.
- Counts the ones in a unipolar bitstream over a fixed window of WINDOW valid samples and presents the result as a binary value.
- Sits at the output of stochastic compute lanes; the result is count_out / WINDOW.

Parameters:
- CNT_W, 8: width of the ones accumulator and of count_out.
- WINDOW, 255: samples per conversion; matches the period of the 8-bit maximal-length LFSR. Legal range 1 .. 2^CNT_W-1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins (or restarts) a conversion window.
- bit_in  in  1  stochastic bitstream sample.
- bit_valid  in  1  bit_in is a valid sample this cycle.
- busy  out  1  high while a window is accumulating.
- done  out  1  one-cycle pulse: count_out was updated this cycle.
- count_out  out  CNT_W  ones count of the last completed window; held until the next completion.

Behaviour:
- Reset: clk and rst are decided as above (asynchronous, active-high reset rst; clock clk). While rst is high: state=IDLE, acc=0, samples=0, count_out=0, done=0, busy=0.
- A reset mid-window discards the partial window; no done is produced.
- States:
  - IDLE: busy=0; bit_valid is ignored. start clears acc and samples and moves to ACCUM.
  - ACCUM: busy=1. Each cycle with bit_valid=1: acc += bit_in and samples += 1.
- Start cycle: bit_in on the cycle start is sampled is not counted. The first sample is taken on the following cycle.
- Completion: the cycle that accepts the WINDOW-th valid sample registers count_out = final acc (including that sample) and done=1 on the next edge, then returns to IDLE.
  - Latency: done and the new count_out are visible 1 cycle after the final sample.
- done is high for exactly one cycle. count_out is stable at all other times.
- start during ACCUM aborts and restarts: acc and samples are cleared, state stays ACCUM, no done. This holds even when start coincides with the WINDOW-th sample; start wins.
- start in the cycle done is high is accepted normally; back-to-back windows are possible with a 1-cycle IDLE gap.
- Widths: acc <= samples <= WINDOW < 2^CNT_W, so acc never overflows and no saturation logic is required. samples uses CNT_W bits.
- Gaps in bit_valid stall the window and never drop samples.
- bit_in is ignored when bit_valid=0.

Optional Feature:
- Macro: SC_DECODER_BIPOLAR_EN.
- Defined:
  - Adds output bipolar_out, signed, width CNT_W+1, equal to 2*count - WINDOW.
  - Registered on the same edge as count_out; reset value is -WINDOW, the bipolar encoding of count 0.
  - Range -WINDOW .. +WINDOW.
- Undefined: the port and its logic are absent; unipolar behaviour is unchanged.

Decomposition:
- Shared package sc_pkg holds:
  - typedef enum sc_dec_state_t {IDLE, ACCUM};
  - localparam SC_DEFAULT_CNT_W = 8;
  - localparam SC_DEFAULT_WINDOW = 255.
- Natural sub-module: sc_ones_counter, a clearable enabled accumulator (clear, en, bit, count) instantiated once.
- The FSM, window counter and output registers stay in the top.

Test Plan (CNT_W=8, WINDOW=255):
- Reset then idle 10 cycles with bit_valid toggling -> count_out=0, busy=0, done never asserted; bipolar_out=-255 if enabled.
- start, then 255 consecutive cycles of bit_valid=1, bit_in=1 -> done pulses exactly 1 cycle after the 255th sample, count_out=255, bipolar_out=+255, busy falls with done.
- start, then 255 valid samples alternating 1,0,1,... -> count_out=128, bipolar_out=+1. Immediately start again with all zeros -> second done, count_out=0.
- start, then bit_valid high every other cycle with bit_in=1 (510 cycles) -> done after the 255th valid sample, count_out=255, no extra counts from invalid cycles.
- start, 100 valid ones, then start again, then 255 valid zeros -> no done at the abort, final count_out=0. Repeat with start coinciding with the 255th sample -> no done, window restarts.
- start, 50 valid ones, assert rst for 2 cycles mid-window -> busy=0, count_out=0, no done. A following full window of 10 ones and 245 zeros -> count_out=10.
